// File: rtl/cnn_pkg.sv
// Shared CNN front-end constants and the 3x3 window packing.
// The convolution stage imports the same packing helper.
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_e;

  // Column-major: byte index of window element (row, col)
  function automatic int win_byte(input int row, input int col);
    return col * 3 + row;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of the convolution window generator.
// Master feeds pixels and observes windows; slave is the generator.
interface conv_window_gen_if #(
  parameter int PW = cnn_pkg::PIX_W,
  parameter int RW = cnn_pkg::ROW_W,
  parameter int CW = cnn_pkg::COL_W
);

  logic          s_valid;
  logic [PW-1:0] s_data;
  logic          s_sof;

  logic            m_valid;
  logic [9*PW-1:0] m_data;
  logic [RW-1:0]   m_row;
  logic [CW-1:0]   m_col;
  logic            m_last;

  modport master (
    output s_valid, s_data, s_sof,
    input  m_valid, m_data, m_row, m_col, m_last
  );

  modport slave (
    input  s_valid, s_data, s_sof,
    output m_valid, m_data, m_row, m_col, m_last
  );

endinterface

// File: rtl/line_buffer.sv
// Single-row pixel store, async read of the old word before the
// clocked write at the same address (LUTRAM/BRAM friendly).
module line_buffer #(
  parameter int DEPTH = cnn_pkg::IMG_W,
  parameter int W     = cnn_pkg::PIX_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to packed 3x3 windows (valid convolution),
// two line buffers, one-cycle latency, never stalls.
module conv_window_gen #(
  parameter int IMG_W = cnn_pkg::IMG_W,
  parameter int IMG_H = cnn_pkg::IMG_H,
  parameter int PIX_W = cnn_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               resetn,
  conv_window_gen_if.slave   bus
);

  import cnn_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = 9 * PIX_W;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [WW-1:0]   win_q;
  logic            m_valid_q;
  logic            m_last_q;
  logic [RW-1:0]   m_row_q;
  logic [CW-1:0]   m_col_q;

  logic            sof;
  logic            acc;
  logic            emit;
  logic            end_c;
  logic            end_r;
  logic [CW-1:0]   pos_c;
  logic [RW-1:0]   pos_r;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [3*PIX_W-1:0] new_col;

  // sof restarts the frame from any state, forcing position (0,0)
  assign sof   = bus.s_valid & bus.s_sof;
  assign acc   = bus.s_valid & (bus.s_sof | (state_q != IDLE));
  assign pos_c = sof ? '0 : col_q;
  assign pos_r = sof ? '0 : row_q;
  assign end_c = (pos_c == CW'(IMG_W - 1));
  assign end_r = (pos_r == RW'(IMG_H - 1));
  assign emit  = (pos_r >= RW'(2)) && (pos_c >= CW'(2));

  line_buffer #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (pos_c),
    .wdata_i (bus.s_data),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (pos_c),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    new_col = '0;
    new_col[win_byte(0, 0)*PIX_W +: PIX_W] = lb1_rd;
    new_col[win_byte(1, 0)*PIX_W +: PIX_W] = lb0_rd;
    new_col[win_byte(2, 0)*PIX_W +: PIX_W] = bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_row_q   <= '0;
      m_col_q   <= '0;
    end else begin
      m_valid_q <= acc & emit;
      m_last_q  <= acc & emit & end_r & end_c;
      if (acc) begin
        // newest column enters at the top bytes
        win_q <= {new_col, win_q[WW-1:3*PIX_W]};
        col_q <= end_c ? '0 : pos_c + 1'b1;
        if (end_c) row_q <= end_r ? '0 : pos_r + 1'b1;
        else       row_q <= pos_r;
        if (emit) begin
          m_row_q <= pos_r - RW'(2);
          m_col_q <= pos_c - CW'(2);
        end
        unique case (1'b1)
          end_r & end_c:
            state_q <= IDLE;
          !end_c && (pos_r >= RW'(2)) && (pos_c >= CW'(1)):
            state_q <= STREAM;
          default:
            state_q <= FILL;
        endcase
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_row   = m_row_q;
  assign bus.m_col   = m_col_q;
  assign bus.m_data  = win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: ramp frames, gaps,
// back-to-back, mid-frame sof and mid-frame reset.
module tb_conv_window_gen;

  import cnn_pkg::*;

  localparam logic [WIN_W-1:0] RAMP_W0 = 72'h3A1E02391D01381C00;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   win_cnt;
  logic [WIN_W-1:0] first_win;

  conv_window_gen_if bus ();

  conv_window_gen dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [WIN_W-1:0] obs,
                     input logic [WIN_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix(input int off,
                                           input int r,
                                           input int c);
    return PIX_W'((r * IMG_W + c + off) & 255);
  endfunction

  // byte (3*col+row) = image pixel (R+row, C+col)
  function automatic logic [WIN_W-1:0] exp_win(input int off,
                                               input int rr,
                                               input int cc);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        w[(3*c+r)*PIX_W +: PIX_W] = pix(off, rr + r, cc + c);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    tick();
    chk("gap_valid", WIN_W'(bus.m_valid), WIN_W'(0));
    if (bus.m_valid) win_cnt++;
  endtask

  task automatic run_frame(input int off, input int gap_pct,
                           input int stop_r, input int stop_c);
    bit ev;
    win_cnt = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if ((r != 0 || c != 0) && ($urandom_range(0, 99) < gap_pct))
          idle_cycle();
        bus.s_valid = 1'b1;
        bus.s_sof   = (r == 0 && c == 0);
        bus.s_data  = pix(off, r, c);
        tick();
        ev = (r >= 2 && c >= 2);
        chk("m_valid", WIN_W'(bus.m_valid), WIN_W'(ev));
        chk("m_last", WIN_W'(bus.m_last),
            WIN_W'(ev && r == IMG_H - 1 && c == IMG_W - 1));
        if (bus.m_valid) win_cnt++;
        if (ev) begin
          chk("m_data", bus.m_data, exp_win(off, r - 2, c - 2));
          chk("m_row", WIN_W'(bus.m_row), WIN_W'(r - 2));
          chk("m_col", WIN_W'(bus.m_col), WIN_W'(c - 2));
          if (r == 2 && c == 2) first_win = bus.m_data;
        end
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;
    first_win   = '0;
    win_cnt     = 0;
    tick();
    tick();
    chk("rst_valid", WIN_W'(bus.m_valid), WIN_W'(0));
    chk("rst_last", WIN_W'(bus.m_last), WIN_W'(0));
    chk("rst_row", WIN_W'(bus.m_row), WIN_W'(0));
    chk("rst_col", WIN_W'(bus.m_col), WIN_W'(0));
    chk("rst_data", bus.m_data, WIN_W'(0));
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = 1'b0;
      bus.s_data  = PIX_W'(i + 1);
      tick();
      chk("nosof_valid", WIN_W'(bus.m_valid), WIN_W'(0));
      chk("nosof_data", bus.m_data, WIN_W'(0));
    end

    run_frame(0, 0, IMG_H, 0);
    chk("f1_count", WIN_W'(win_cnt), WIN_W'(676));
    chk("f1_first", first_win, RAMP_W0);

    run_frame(85, 0, IMG_H, 0);
    chk("f2_count", WIN_W'(win_cnt), WIN_W'(676));

    idle_cycle();
    idle_cycle();

    run_frame(0, 43, IMG_H, 0);
    chk("gap_count", WIN_W'(win_cnt), WIN_W'(676));
    chk("gap_first", first_win, RAMP_W0);

    run_frame(0, 0, 10, 5);
    run_frame(7, 0, IMG_H, 0);
    chk("resof_count", WIN_W'(win_cnt), WIN_W'(676));
    chk("resof_first", first_win, exp_win(7, 0, 0));

    run_frame(0, 0, 15, 15);
    resetn      = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b0;
    bus.s_data  = pix(0, 15, 15);
    tick();
    chk("mrst_valid", WIN_W'(bus.m_valid), WIN_W'(0));
    chk("mrst_last", WIN_W'(bus.m_last), WIN_W'(0));
    chk("mrst_row", WIN_W'(bus.m_row), WIN_W'(0));
    chk("mrst_col", WIN_W'(bus.m_col), WIN_W'(0));
    chk("mrst_data", bus.m_data, WIN_W'(0));
    resetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = 1'b0;
      bus.s_data  = pix(0, 15, 16 + i);
      tick();
      chk("post_rst_valid", WIN_W'(bus.m_valid), WIN_W'(0));
      chk("post_rst_data", bus.m_data, WIN_W'(0));
    end

    run_frame(3, 0, IMG_H, 0);
    chk("f_last_count", WIN_W'(win_cnt), WIN_W'(676));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 3x3 convolution stage.
- Accepts a raster-order 8-bit pixel stream, one MNIST frame of IMG_H x IMG_W, and buffers two previous rows in line buffers.
- Emits one packed 3x3 window per cycle on a 72-bit bus that connects directly to the convolution's i_data.
- Valid (unpadded) convolution only: a 28x28 frame produces 26x26 windows.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- PIX_W, 8, pixel width in bits (window bus = 9*PIX_W).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- s_valid  in  1  pixel strobe; one pixel is accepted per cycle when high (no backpressure).
- s_data  in  PIX_W  pixel value, unsigned.
- s_sof  in  1  start of frame; qualified by s_valid; marks pixel (0,0).
- m_valid  out  1  window strobe.
- m_data  out  9*PIX_W  packed 3x3 window.
- m_row  out  $clog2(IMG_H)  output row index of window, 0..IMG_H-3.
- m_col  out  $clog2(IMG_W)  output column index of window, 0..IMG_W-3.
- m_last  out  1  high with the final window of a frame.

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clk.
  - During reset: m_valid=0, m_last=0, m_row=0, m_col=0, m_data=0, counters=0, state=IDLE.
  - Line buffer contents are not cleared; their stale data is never emitted.
- Counters:
  - col_cnt increments on each accepted pixel and wraps at IMG_W-1, at which point row_cnt increments.
  - row_cnt wraps at IMG_H-1.
  - Pixel (IMG_H-1, IMG_W-1) returns both counters to 0.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each IMG_W deep, indexed by col_cnt.
  - On accept: lb1[col] <= lb0[col], lb0[col] <= s_data.
  - Both are read before the write in the same cycle.
- Window registers:
  - On accept, the window shifts one column left.
  - The new right column is {top: lb1[col], mid: lb0[col], bot: s_data}.
- Packing (column-major): byte k = window(row k%3, col k/3).
  - byte0=(0,0), byte1=(1,0), byte2=(2,0), byte3=(0,1) ... byte8=(2,2).
  - Window row 0 is the oldest image row; column 0 is the leftmost.
- Emission and latency:
  - When a pixel is accepted with row_cnt>=2 and col_cnt>=2, m_valid is high the next cycle.
  - m_row=row_cnt-2, m_col=col_cnt-2.
  - m_last=1 when (row_cnt, col_cnt) = (IMG_H-1, IMG_W-1).
  - Latency is 1 cycle; m_valid is a single-cycle pulse per window.
- Bubbles: s_valid low holds all state and drives m_valid=0 the next cycle; output is unaffected otherwise.
- FSM:
  - IDLE: waits for s_valid & s_sof; pixels without sof are dropped.
  - FILL: rows 0-1 and columns 0-1 of each row; no output.
  - STREAM: emitting windows.
  - After the final pixel the FSM goes to IDLE. If s_sof coincides with the next valid pixel it re-enters directly, so back-to-back frames need no gap cycle.
- s_sof mid-frame: counters are forced so that pixel is (0,0); the FSM enters FILL; the partial frame is abandoned with no m_last. Windows already emitted stay valid.
- Reset mid-frame: the partial frame is abandoned; the next frame requires s_sof.
- The convolution stage has no ready; this block never stalls.

Decomposition:
- Shared package cnn_pkg: IMG_W, IMG_H, PIX_W, WIN_W=9*PIX_W, and a win_byte(row,col) index constant/function. The convolution stage imports the same packing from it.
- One natural sub-module: line_buffer (single-row RAM, depth IMG_W, read-before-write at one address), instantiated twice, maps to LUTRAM/BRAM.
- Counters, FSM and window registers stay in the top module.

Test Plan:
- Ramp frame: s_sof on first pixel, p(r,c)=(r*28+c)&0xFF, continuous valid.
  - First m_valid is 1 cycle after pixel (2,2), with m_data=0x3A1E02391D0138_1C00 (bytes 8..0 = 58,30,2,57,29,1,56,28,0), m_row=0, m_col=0.
  - Exactly 676 windows.
- Same frame with random s_valid gaps (~30% idle): the window sequence and data are bit-identical to the continuous run, and m_valid never occurs during rows 0-1 or columns 0-1.
- End of frame: m_last is high only on window (25,25). Second frame starts on the very next cycle with s_sof: its first window is correct, with no stale row data from frame 1.
- Pixels without s_sof after reset: no m_valid. Then s_sof arrives and the frame is processed normally.
- s_sof asserted at pixel (10,5) of a running frame: no m_last for the old frame, the next window appears after new pixel (2,2), and 676 windows follow.
- resetn low for 1 cycle at pixel (15,15): m_valid is 0 the next cycle, and outputs stay 0 until a new s_sof frame is received.
